// File: rtl/i2cs_pkg.sv
// i2cs_pkg: register offsets, ID constant and control bit positions shared by the I2C slave mailbox.
package i2cs_pkg;
    localparam logic [7:0] I2CS_ID_DEF  = 8'hA5;
    localparam logic [7:0] I2C_ID       = 8'h00;
    localparam logic [7:0] I2C_I2A_PUSH = 8'h10;
    localparam logic [7:0] I2C_I2A_CNT  = 8'h11;
    localparam logic [7:0] I2C_A2I_HEAD = 8'h20;
    localparam logic [7:0] I2C_A2I_CNT  = 8'h21;
    localparam logic [7:0] I2C_OVF      = 8'h22;
    localparam logic [5:0] APB_CTRL     = 6'h00;
    localparam logic [5:0] APB_DEB      = 6'h04;
    localparam logic [5:0] APB_SCL      = 6'h08;
    localparam logic [5:0] APB_SDA      = 6'h0C;
    localparam logic [5:0] APB_POP      = 6'h10;
    localparam logic [5:0] APB_PUSH     = 6'h14;
    localparam logic [5:0] APB_STAT     = 6'h18;
    localparam logic [5:0] APB_FLUSH    = 6'h1C;
    localparam logic [5:0] APB_IRQ      = 6'h20;
    localparam int FLUSH_I2A     = 0;
    localparam int FLUSH_A2I     = 1;
    localparam int CLR_OVF       = 2;
    localparam int IRQ_I2A_NE    = 0;
    localparam int IRQ_A2I_EMPTY = 1;
    localparam logic [7:0] DLY_RST = 8'h14;
endpackage

// File: rtl/i2cs_sync_fifo.sv
// i2cs_sync_fifo: byte FIFO with exact count, sticky overflow and flush; head reads 0 when empty.
module i2cs_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic                     clr_ovf_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic ovf_q, do_push, do_pop;
    assign empty_o    = cnt_q == '0;
    assign full_o     = cnt_q == CW'(DEPTH);
    assign do_pop     = pop_i & ~empty_o;
    // a pop in the same cycle frees the slot a push into a full FIFO needs
    assign do_push    = push_i & (~full_o | do_pop);
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;
    assign rdata_o    = empty_o ? '0 : mem_q[rd_q];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q & ~clr_ovf_i) | (push_i & ~do_push & ~flush_i);
            if (flush_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                wr_q  <= wr_q + AW'(do_push);
                rd_q  <= rd_q + AW'(do_pop);
                cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
            end
        end
    end
    always_ff @(posedge clk_i)
        if (do_push & ~flush_i) mem_q[wr_q] <= wdata_i;
endmodule

// File: rtl/i2cs_mailbox_regs.sv
// i2cs_mailbox_regs: I2C-engine register map, APB config/mailbox registers and two byte FIFOs.
// Build option I2CS_MAILBOX_IRQ_EN adds the APB 0x20 irq enable register and a registered irq_o.
module i2cs_mailbox_regs
    import i2cs_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] I2CS_ID      = I2CS_ID_DEF,
    parameter logic [6:0] DEF_DEV_ADDR = 7'h6F
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [11:0] paddr_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    input  logic [7:0]  i2c_reg_addr_i,
    input  logic [7:0]  i2c_reg_wdata_i,
    input  logic        i2c_reg_wrenable_i,
    input  logic        i2c_reg_rd_byte_complete_i,
    output logic [7:0]  i2c_reg_rddata_o,
    output logic [6:0]  i2c_dev_addr_o,
    output logic        i2c_enabled_o,
    output logic [7:0]  i2c_debounce_len_o,
    output logic [7:0]  i2c_scl_delay_len_o,
    output logic [7:0]  i2c_sda_delay_len_o,
    output logic        irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [6:0] dev_addr_q;
    logic en_q;
    logic [7:0] deb_q, scl_q, sda_q;
    logic [31:0] prdata_q, prdata_d;
    logic [5:0] off;
    logic apb_setup, apb_rd, apb_wr;
    logic i2a_push, i2a_pop, i2a_flush, i2a_clr, i2a_full, i2a_empty, i2a_ovf;
    logic a2i_push, a2i_pop, a2i_flush, a2i_clr, a2i_full, a2i_empty, a2i_ovf;
    logic [7:0] i2a_head, a2i_head;
    logic [CW-1:0] i2a_cnt, a2i_cnt;
    logic [8:0] i2a_cnt9, a2i_cnt9;
    logic unused_bits;
    // only word offsets 0x00..0x20 are decoded; upper address and byte-lane bits alias
    assign off       = {paddr_i[5:2], 2'b00};
    assign apb_setup = psel_i & ~penable_i;
    assign apb_rd    = psel_i & penable_i & ~pwrite_i;
    assign apb_wr    = psel_i & penable_i & pwrite_i;
    assign pready_o  = 1'b1;
    assign prdata_o  = prdata_q;
    assign i2a_cnt9  = 9'(i2a_cnt);
    assign a2i_cnt9  = 9'(a2i_cnt);
    assign i2a_push  = i2c_reg_wrenable_i & (i2c_reg_addr_i == I2C_I2A_PUSH);
    assign i2a_pop   = apb_rd & (off == APB_POP);
    assign a2i_push  = apb_wr & (off == APB_PUSH);
    assign a2i_pop   = i2c_reg_rd_byte_complete_i & (i2c_reg_addr_i == I2C_A2I_HEAD);
    assign i2a_flush = apb_wr & (off == APB_FLUSH) & pwdata_i[FLUSH_I2A];
    assign a2i_flush = apb_wr & (off == APB_FLUSH) & pwdata_i[FLUSH_A2I];
    assign a2i_clr   = apb_wr & (off == APB_FLUSH) & pwdata_i[CLR_OVF];
    assign i2a_clr   = a2i_clr | (i2c_reg_wrenable_i & (i2c_reg_addr_i == I2C_OVF) & i2c_reg_wdata_i[0]);
    assign unused_bits = ^{paddr_i[11:6], paddr_i[1:0], pwdata_i[31:9], i2a_full, a2i_full};
    i2cs_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_i2a (
        .clk_i, .rst_ni, .push_i(i2a_push), .pop_i(i2a_pop), .flush_i(i2a_flush),
        .clr_ovf_i(i2a_clr), .wdata_i(i2c_reg_wdata_i), .rdata_o(i2a_head), .count_o(i2a_cnt),
        .full_o(i2a_full), .empty_o(i2a_empty), .overflow_o(i2a_ovf)
    );
    i2cs_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_a2i (
        .clk_i, .rst_ni, .push_i(a2i_push), .pop_i(a2i_pop), .flush_i(a2i_flush),
        .clr_ovf_i(a2i_clr), .wdata_i(pwdata_i[7:0]), .rdata_o(a2i_head), .count_o(a2i_cnt),
        .full_o(a2i_full), .empty_o(a2i_empty), .overflow_o(a2i_ovf)
    );
`ifdef I2CS_MAILBOX_IRQ_EN
    logic [1:0] irq_en_q;
    logic irq_q;
    assign irq_o = irq_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (apb_wr && off == APB_IRQ) irq_en_q <= pwdata_i[1:0];
            irq_q <= (irq_en_q[IRQ_I2A_NE] & ~i2a_empty) | (irq_en_q[IRQ_A2I_EMPTY] & a2i_empty);
        end
    end
`else
    assign irq_o = 1'b0;
`endif
    always_comb begin
        prdata_d = '0;
        case (off)
            APB_CTRL:  prdata_d = {23'b0, en_q, 1'b0, dev_addr_q};
            APB_DEB:   prdata_d = {24'b0, deb_q};
            APB_SCL:   prdata_d = {24'b0, scl_q};
            APB_SDA:   prdata_d = {24'b0, sda_q};
            APB_POP:   prdata_d = {24'b0, i2a_head};
            APB_STAT:  prdata_d = {a2i_ovf, 6'b0, a2i_cnt9, 7'b0, i2a_cnt9};
`ifdef I2CS_MAILBOX_IRQ_EN
            APB_IRQ:   prdata_d = {30'b0, irq_en_q};
`endif
            default:   prdata_d = '0;
        endcase
    end
    always_comb begin
        i2c_reg_rddata_o = 8'h00;
        case (i2c_reg_addr_i)
            I2C_ID:       i2c_reg_rddata_o = I2CS_ID;
            I2C_I2A_CNT:  i2c_reg_rddata_o = i2a_cnt9[7:0];
            I2C_A2I_HEAD: i2c_reg_rddata_o = a2i_head;
            I2C_A2I_CNT:  i2c_reg_rddata_o = a2i_cnt9[7:0];
            I2C_OVF:      i2c_reg_rddata_o = {7'b0, i2a_ovf};
            default:      i2c_reg_rddata_o = 8'h00;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dev_addr_q <= DEF_DEV_ADDR;
            en_q       <= 1'b0;
            deb_q      <= DLY_RST;
            scl_q      <= DLY_RST;
            sda_q      <= DLY_RST;
            prdata_q   <= '0;
        end else begin
            if (apb_setup) prdata_q <= prdata_d;
            if (apb_wr && off == APB_CTRL) begin
                dev_addr_q <= pwdata_i[6:0];
                en_q       <= pwdata_i[8];
            end
            if (apb_wr && off == APB_DEB) deb_q <= pwdata_i[7:0];
            if (apb_wr && off == APB_SCL) scl_q <= pwdata_i[7:0];
            if (apb_wr && off == APB_SDA) sda_q <= pwdata_i[7:0];
        end
    end
    assign i2c_dev_addr_o      = dev_addr_q;
    assign i2c_enabled_o       = en_q;
    assign i2c_debounce_len_o  = deb_q;
    assign i2c_scl_delay_len_o = scl_q;
    assign i2c_sda_delay_len_o = sda_q;
endmodule

// File: tb/tb_i2cs_mailbox_regs.sv
// tb_i2cs_mailbox_regs: table-driven checks of the mailbox register block plus multi-cycle corner sequences.
module tb_i2cs_mailbox_regs;
    logic clk_i = 1'b0, rst_ni = 1'b0;
    logic [11:0] paddr_i = '0;
    logic psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
    logic [31:0] pwdata_i = '0, prdata_o;
    logic pready_o;
    logic [7:0] i2c_reg_addr_i = '0, i2c_reg_wdata_i = '0, i2c_reg_rddata_o;
    logic i2c_reg_wrenable_i = 1'b0, i2c_reg_rd_byte_complete_i = 1'b0;
    logic [6:0] i2c_dev_addr_o;
    logic i2c_enabled_o, irq_o;
    logic [7:0] i2c_debounce_len_o, i2c_scl_delay_len_o, i2c_sda_delay_len_o;
    int checks = 0, errors = 0;

    typedef enum int {APB_WR, APB_RD, I2C_WR, I2C_RD, I2C_POP} op_t;
    typedef struct {
        op_t         op;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vq[$];

    always #5 clk_i = ~clk_i;

    i2cs_mailbox_regs dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .paddr_i(paddr_i), .psel_i(psel_i), .penable_i(penable_i),
        .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o), .pready_o(pready_o),
        .i2c_reg_addr_i(i2c_reg_addr_i), .i2c_reg_wdata_i(i2c_reg_wdata_i),
        .i2c_reg_wrenable_i(i2c_reg_wrenable_i), .i2c_reg_rd_byte_complete_i(i2c_reg_rd_byte_complete_i),
        .i2c_reg_rddata_o(i2c_reg_rddata_o), .i2c_dev_addr_o(i2c_dev_addr_o), .i2c_enabled_o(i2c_enabled_o),
        .i2c_debounce_len_o(i2c_debounce_len_o), .i2c_scl_delay_len_o(i2c_scl_delay_len_o),
        .i2c_sda_delay_len_o(i2c_sda_delay_len_o), .irq_o(irq_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void add(op_t op, logic [11:0] addr, logic [31:0] data, logic [31:0] exp, string name);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.exp = exp; v.name = name;
        vq.push_back(v);
    endfunction

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = a; pwdata_i = d;
        @(negedge clk_i);
        penable_i = 1'b1;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk_i);
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = a;
        @(negedge clk_i);
        penable_i = 1'b1;
        #1 d = prdata_o;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0;
    endtask

    task automatic i2c_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk_i);
        i2c_reg_addr_i = a; i2c_reg_wdata_i = d; i2c_reg_wrenable_i = 1'b1;
        @(negedge clk_i);
        i2c_reg_wrenable_i = 1'b0;
    endtask

    task automatic i2c_read(input logic [7:0] a, output logic [7:0] d);
        i2c_reg_addr_i = a;
        #1 d = i2c_reg_rddata_o;
    endtask

    initial begin
        logic [31:0] d32;
        logic [7:0]  d8;
        // reset / ID / defaults
        add(I2C_RD, 12'h000, 0, 32'hA5, "id");
        add(I2C_RD, 12'h011, 0, 32'h00, "i2a_cnt_rst");
        add(I2C_RD, 12'h021, 0, 32'h00, "a2i_cnt_rst");
        add(I2C_RD, 12'h022, 0, 32'h00, "ovf_rst");
        add(I2C_RD, 12'h055, 0, 32'h00, "i2c_unmapped");
        add(APB_RD, 12'h018, 0, 32'h0, "stat_rst");
        add(APB_RD, 12'h000, 0, 32'h6F, "ctrl_rst");
        add(APB_RD, 12'h00C, 0, 32'h14, "sda_rst");
        // I2C -> APB
        add(I2C_WR, 12'h010, 32'h11, 0, "");
        add(I2C_WR, 12'h010, 32'h22, 0, "");
        add(I2C_WR, 12'h010, 32'h33, 0, "");
        add(I2C_RD, 12'h011, 0, 32'h3, "i2a_cnt3");
        add(APB_RD, 12'h018, 0, 32'h3, "stat_i2a3");
        add(APB_RD, 12'h010, 0, 32'h11, "pop1");
        add(APB_RD, 12'h010, 0, 32'h22, "pop2");
        add(APB_RD, 12'h010, 0, 32'h33, "pop3");
        add(APB_RD, 12'h010, 0, 32'h00, "pop_empty");
        add(APB_RD, 12'h018, 0, 32'h0, "stat_i2a0");
        // APB -> I2C with overflow
        for (int i = 1; i <= 9; i++) add(APB_WR, 12'h014, i, 0, "");
        add(APB_RD, 12'h018, 0, 32'h8008_0000, "stat_full_ovf");
        add(I2C_RD, 12'h021, 0, 32'h8, "a2i_cnt8");
        for (int i = 1; i <= 8; i++) add(I2C_POP, 12'h020, 0, i, "a2i_head");
        add(I2C_RD, 12'h021, 0, 32'h0, "a2i_cnt0");
        add(I2C_RD, 12'h020, 0, 32'h0, "a2i_head_empty");
        add(APB_RD, 12'h018, 0, 32'h8000_0000, "stat_ovf_sticky");
        add(APB_WR, 12'h01C, 32'h4, 0, "");
        add(APB_RD, 12'h018, 0, 32'h0, "stat_ovf_clr");
        // config registers
        add(APB_WR, 12'h000, 32'h123, 0, "");
        add(APB_WR, 12'h004, 32'h33, 0, "");
        add(APB_WR, 12'h024, 32'hFF, 0, "");
        add(APB_RD, 12'h000, 0, 32'h123, "ctrl_rw");
        add(APB_RD, 12'h004, 0, 32'h33, "deb_rw");
        add(APB_RD, 12'h024, 0, 32'h0, "apb_unmapped");

        repeat (3) @(negedge clk_i);
        chk("rst_en", 32'(i2c_enabled_o), 0);
        chk("rst_dev", 32'(i2c_dev_addr_o), 32'h6F);
        chk("rst_deb", 32'(i2c_debounce_len_o), 32'h14);
        chk("rst_scl", 32'(i2c_scl_delay_len_o), 32'h14);
        chk("rst_irq", 32'(irq_o), 0);
        chk("pready", 32'(pready_o), 1);
        rst_ni = 1'b1;

        foreach (vq[i]) begin
            case (vq[i].op)
                APB_WR: apb_write(vq[i].addr, vq[i].data);
                I2C_WR: i2c_write(vq[i].addr[7:0], vq[i].data[7:0]);
                APB_RD: begin
                    apb_read(vq[i].addr, d32);
                    chk(vq[i].name, d32, vq[i].exp);
                end
                I2C_RD: begin
                    i2c_read(vq[i].addr[7:0], d8);
                    chk(vq[i].name, 32'(d8), vq[i].exp);
                end
                default: begin
                    @(negedge clk_i);
                    i2c_read(vq[i].addr[7:0], d8);
                    chk(vq[i].name, 32'(d8), vq[i].exp);
                    i2c_reg_rd_byte_complete_i = 1'b1;
                    @(negedge clk_i);
                    i2c_reg_rd_byte_complete_i = 1'b0;
                end
            endcase
        end
        chk("cfg_en", 32'(i2c_enabled_o), 1);
        chk("cfg_dev", 32'(i2c_dev_addr_o), 32'h23);
        chk("cfg_deb", 32'(i2c_debounce_len_o), 32'h33);

        // full FIFO: APB push and I2C pop in the same cycle
        for (int i = 0; i < 8; i++) apb_write(12'h014, 32'hA0 + i);
        @(negedge clk_i);
        psel_i = 1'b1; pwrite_i = 1'b1; paddr_i = 12'h014; pwdata_i = 32'hAA;
        @(negedge clk_i);
        penable_i = 1'b1; i2c_reg_addr_i = 8'h20; i2c_reg_rd_byte_complete_i = 1'b1;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; i2c_reg_rd_byte_complete_i = 1'b0;
        i2c_read(8'h21, d8);
        chk("full_pushpop_cnt", 32'(d8), 8);
        i2c_read(8'h20, d8);
        chk("full_pushpop_head", 32'(d8), 32'hA1);
        apb_read(12'h018, d32);
        chk("full_pushpop_noovf", d32, 32'h0008_0000);

        // flush of I2C->APB in the same cycle as an I2C push
        i2c_write(8'h10, 8'h01);
        i2c_write(8'h10, 8'h02);
        @(negedge clk_i);
        psel_i = 1'b1; pwrite_i = 1'b1; paddr_i = 12'h01C; pwdata_i = 32'h1;
        @(negedge clk_i);
        penable_i = 1'b1; i2c_reg_addr_i = 8'h10; i2c_reg_wdata_i = 8'h77; i2c_reg_wrenable_i = 1'b1;
        @(negedge clk_i);
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; i2c_reg_wrenable_i = 1'b0;
        apb_read(12'h018, d32);
        chk("flush_wins", d32, 32'h0008_0000);

        // I2C->APB overflow flag and its W1C from the engine side
        for (int i = 0; i < 9; i++) i2c_write(8'h10, 8'(i));
        i2c_read(8'h22, d8);
        chk("i2a_ovf_set", 32'(d8), 1);
        i2c_write(8'h22, 8'h01);
        i2c_read(8'h22, d8);
        chk("i2a_ovf_w1c", 32'(d8), 0);
        apb_write(12'h01C, 32'h1);
        for (int i = 0; i < 5; i++) i2c_write(8'h10, 8'(i + 16));
        i2c_read(8'h11, d8);
        chk("pre_rst_cnt", 32'(d8), 5);

        // asynchronous reset mid-transfer
        @(negedge clk_i);
        rst_ni = 1'b0;
        i2c_read(8'h11, d8);
        chk("arst_i2a_cnt", 32'(d8), 0);
        i2c_read(8'h21, d8);
        chk("arst_a2i_cnt", 32'(d8), 0);
        chk("arst_dev", 32'(i2c_dev_addr_o), 32'h6F);
        chk("arst_en", 32'(i2c_enabled_o), 0);
        chk("arst_deb", 32'(i2c_debounce_len_o), 32'h14);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // interrupt behaviour
`ifdef I2CS_MAILBOX_IRQ_EN
        apb_write(12'h020, 32'h1);
        apb_read(12'h020, d32);
        chk("irq_en_rd", d32, 1);
        chk("irq_idle", 32'(irq_o), 0);
        i2c_write(8'h10, 8'h55);
        chk("irq_latency", 32'(irq_o), 0);
        @(negedge clk_i);
        chk("irq_set", 32'(irq_o), 1);
        apb_read(12'h010, d32);
        chk("irq_pop_data", d32, 32'h55);
        @(negedge clk_i);
        chk("irq_clr", 32'(irq_o), 0);
`else
        apb_write(12'h020, 32'h3);
        apb_read(12'h020, d32);
        chk("irq_en_absent", d32, 0);
        i2c_write(8'h10, 8'h55);
        @(negedge clk_i);
        chk("irq_tied0", 32'(irq_o), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
